// File: rtl/fp_normalize_stage.sv
`default_nettype none
// ============================================================================
// Module  : fp_normalize_stage
// Brief   : Two-stage normalize/pack of a raw FP add result into IEEE-754 single
// Rev     : 1.0  initial release
// ============================================================================
module fp_normalize_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_zero,
  output logic [15:0] ovf_count
);

  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [24:0] s1_mant;
  logic [4:0]  s1_lz;
  logic        s1_carry;
  logic        s2_valid;
  logic        adv1;
  logic        adv2;
  logic [23:0] shifted;
  logic [31:0] nxt_result;
  logic        nxt_ovf;
  logic        nxt_zero;

  function automatic logic [4:0] count_lz(input logic [23:0] m);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && m[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= 8'd0;
      s1_mant  <= 25'd0;
      s1_lz    <= 5'd0;
      s1_carry <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_exp   <= in_exp;
        s1_mant  <= in_mant;
        s1_lz    <= count_lz(in_mant[23:0]);
        s1_carry <= in_mant[24];
      end
    end
  end

  // Priority: zero, carry (with overflow), already normal, shift, underflow.
  always_comb begin
    shifted    = s1_mant[23:0] << s1_lz;
    nxt_result = 32'd0;
    nxt_ovf    = 1'b0;
    nxt_zero   = 1'b0;
    if (s1_mant == 25'd0) begin
      nxt_zero = 1'b1;
    end else if (s1_carry) begin
      if (s1_exp >= 8'd254) begin
        nxt_result = {s1_sign, 8'hFF, 23'd0};
        nxt_ovf    = 1'b1;
      end else begin
        nxt_result = {s1_sign, s1_exp + 8'd1, s1_mant[23:1]};
      end
    end else if (s1_lz == 5'd0) begin
      nxt_result = {s1_sign, s1_exp, s1_mant[22:0]};
    end else if (s1_exp > {3'd0, s1_lz}) begin
      nxt_result = {s1_sign, s1_exp - {3'd0, s1_lz}, shifted[22:0]};
    end else begin
      nxt_zero = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      out_result   <= 32'd0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result   <= nxt_result;
        out_overflow <= nxt_ovf;
        out_zero     <= nxt_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= 16'd0;
    end else if (out_valid && out_ready && out_overflow && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/fp_normalize_stage.md
# fp_normalize_stage

Registered normalization and packing stage that sits directly downstream of the combinational floating-point adder. It consumes the adder's raw sign, selected exponent and 25-bit unnormalized mantissa (carry, hidden bit and fraction). It produces a packed IEEE-754 single-precision result with overflow and zero flags. It is a two-stage pipeline with a valid/ready handshake on both sides, so the adder datapath can be retimed and back-pressured by the consumer.

## Interface
- No parameters; all widths are fixed to single precision.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream holds a valid raw sum
- in_ready  output  1  stage accepts the input this cycle
- in_sign  input  1  result sign from the adder
- in_exp  input  8  larger operand exponent from the adder
- in_mant  input  25  raw mantissa: bit 24 = carry, bit 23 = hidden bit, bits 22:0 = fraction
- out_valid  output  1  out_result is valid
- out_ready  input  1  downstream accepts the output this cycle
- out_result  output  32  packed {sign, exponent[7:0], fraction[22:0]}
- out_overflow  output  1  result was forced to infinity
- out_zero  output  1  result was flushed to +0 (zero mantissa or underflow)
- ovf_count  output  16  saturating count of overflow results delivered (out_valid & out_ready & out_overflow)

## Operation
- Transfer occurs on a rising edge when valid & ready are both high.
- S1 (capture):
  - Registers sign, exp and mant.
  - Computes lz, the number of leading zeros of mant[23:0] (0..23, or 24 if zero).
  - Registers carry = mant[24].
- S2 (normalize and pack), with priority top to bottom:
  - mant == 0: result 32'h0000_0000, out_zero = 1.
  - carry = 1:
    - If exp >= 254: result {sign, 8'hFF, 23'h0}, out_overflow = 1.
    - Otherwise: fraction = mant[23:1] (truncate, no rounding), exponent = exp + 1.
  - carry = 0 and lz == 0: pass through; fraction = mant[22:0], exponent = exp.
  - carry = 0, lz > 0, exp > lz:
    - Shift mant left by lz.
    - fraction = shifted[22:0], exponent = exp - lz.
  - carry = 0, lz > 0, exp <= lz: underflow; result 32'h0000_0000, out_zero = 1 (no denormals).
- Flags out_overflow and out_zero are mutually exclusive and travel with out_result.
- Rounding mode is truncation toward zero; discarded bits are dropped.
- ovf_count:
  - Increments on each overflow output transfer.
  - Saturates at 16'hFFFF.
  - Clears only on rst.

## Timing
- Latency is 2 cycles from input transfer to out_valid when out_ready is held high.
- Throughput is one result per cycle.
- Pipeline control:
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1
- in_ready depends combinationally on out_ready; there is no skid buffer.
- When s2 holds and out_ready = 0:
  - out_result and flags stay stable.
  - S1 holds if it is valid.
- The stage holds at most 2 results; the third input sees in_ready = 0 until out_ready rises.
- In a cycle where an input and an output transfer together, both happen and no item is lost or duplicated.
- Order is strictly preserved.
- Reset (asynchronous assert, at any time including mid-stall):
  - s1_valid, s2_valid, out_valid = 0.
  - out_result = 0, out_overflow = 0, out_zero = 0, ovf_count = 0.
  - in_ready = 1 from the first cycle after deassertion.
  - In-flight data is discarded.
- Deassertion is synchronous to clk through the standard reset synchronizer upstream.

## Test plan
- 1.0 + 1.0 (sign 0, exp 127, mant 25'h100_0000) with out_ready = 1 -> out_result 32'h4000_0000 two cycles later, both flags 0.
- Cancellation (sign 0, exp 127, mant 25'h000_0001) -> out_result 32'h3400_0000, flags 0.
- Overflow (sign 1, exp 254, mant 25'h180_0000) -> out_result 32'hFF80_0000, out_overflow = 1, ovf_count = 1 after transfer.
- Zero and underflow:
  - mant = 0, exp 100 -> 32'h0000_0000, out_zero = 1.
  - exp 3, mant 25'h000_0010 (lz = 19) -> 32'h0000_0000, out_zero = 1.
- Back-pressure: stream 4 inputs back-to-back with out_ready = 0 for 5 cycles, then 1 -> in_ready falls after 2 accepts, 4 results emerge in order, none lost or duplicated.
- Assert rst while 2 results are stalled -> out_valid = 0 immediately, ovf_count = 0, first post-reset input emerges 2 cycles after acceptance.
